// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: pixel-rate enable, h/v counters, and
// registered sync/blanking decode kept cycle-aligned with pixel_x/pixel_y.
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FP + V_SYNC);

    logic [DIV_W-1:0] r_div;
    logic             r_tick;
    logic [9:0]       r_h;
    logic [9:0]       r_v;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video;
    logic             r_frame;

    logic             w_div_last;
    logic             w_h_last;
    logic             w_v_last;
    logic [9:0]       w_h_next;
    logic [9:0]       w_v_next;
    logic             w_hsync_next;
    logic             w_vsync_next;
    logic             w_video_next;
    logic             w_frame_next;

    always_comb begin
        w_div_last = (r_div == DIV_LAST);
        w_h_last   = (r_h == H_LAST);
        w_v_last   = (r_v == V_LAST);
        w_h_next   = r_h;
        w_v_next   = r_v;
        if (r_tick) begin
            w_h_next = w_h_last ? '0 : r_h + 10'd1;
            if (w_h_last) begin
                w_v_next = w_v_last ? '0 : r_v + 10'd1;
            end
        end
    end

    // Decode from next-state counts so registered syncs land with pixel_x/y.
    always_comb begin
        w_hsync_next = !((w_h_next >= HS_START) && (w_h_next < HS_END));
        w_vsync_next = !((w_v_next >= VS_START) && (w_v_next < VS_END));
        w_video_next = (w_h_next < H_VIS) && (w_v_next < V_VIS);
        w_frame_next = w_div_last && (w_h_next == H_LAST) && (w_v_next == V_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div   <= '0;
            r_tick  <= 1'b0;
            r_h     <= '0;
            r_v     <= '0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_video <= 1'b1;
            r_frame <= 1'b0;
        end else begin
            r_div   <= w_div_last ? '0 : r_div + DIV_W'(1);
            r_tick  <= w_div_last;
            r_h     <= w_h_next;
            r_v     <= w_v_next;
            r_hsync <= w_hsync_next;
            r_vsync <= w_vsync_next;
            r_video <= w_video_next;
            r_frame <= w_frame_next;
        end
    end

    assign p_tick      = r_tick;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video;
    assign pixel_x     = r_h;
    assign pixel_y     = r_v;
    assign frame_start = r_frame;

endmodule
